// File: rtl/secuenciador_matriz_4x4.sv
// Sequencer for a complex 4x4 matrix product through an external multiplier.
// Optional WAIT watchdog enabled by defining SECUENCIADOR_TIMEOUT_EN.
module secuenciador_matriz_4x4 #(
  parameter int Width = 8
) (
  input  logic               CLK,
  input  logic               MasterReset,
  input  logic               LoadEn,
  input  logic               LoadSel,
  input  logic [3:0]         LoadAddr,
  input  logic [Width-1:0]   LoadReal,
  input  logic [Width-1:0]   LoadImag,
  input  logic               Start,
  output logic               Busy,
  output logic               Done,
  output logic               MulEnable,
  output logic               MulStart,
  output logic [4*Width-1:0] FilaReal,
  output logic [4*Width-1:0] FilaImag,
  output logic [4*Width-1:0] ColumReal,
  output logic [4*Width-1:0] ColumImag,
  input  logic               MulListo,
  input  logic [Width-1:0]   MulOutReal,
  input  logic [Width-1:0]   MulOutImag,
  input  logic               MulError,
  input  logic [3:0]         RdAddr,
  output logic [Width-1:0]   RdReal,
  output logic [Width-1:0]   RdImag,
  output logic [15:0]        ErrorMask,
  output logic               ErrorAny
);
  typedef enum logic [2:0] {
    IDLE, ISSUE, WAIT, CAPTURE, RELEASE, DONE
  } state_t;

  state_t state, state_nx;
  logic [3:0] idx, nx_idx;
  logic [Width-1:0] a_re [16];
  logic [Width-1:0] a_im [16];
  logic [Width-1:0] b_re [16];
  logic [Width-1:0] b_im [16];
  logic [Width-1:0] c_re [16];
  logic [Width-1:0] c_im [16];
  logic [Width-1:0] a_re_f [16];
  logic [Width-1:0] a_im_f [16];
  logic [Width-1:0] b_re_f [16];
  logic [Width-1:0] b_im_f [16];
  logic [4*Width-1:0] fr_nx, fi_nx, cr_nx, ci_nx;
  logic busy, done, idle_like, load_ok, start_ok;
  logic [15:0] err_mask;
`ifdef SECUENCIADOR_TIMEOUT_EN
  logic [7:0] wd;
`endif

  assign idle_like = (state == IDLE) || (state == DONE);
  assign load_ok   = idle_like && LoadEn;
  assign start_ok  = idle_like && Start;
  assign nx_idx    = (state == RELEASE) ? idx + 4'd1 : 4'd0;

  // A write coinciding with Start is forwarded so element 0 sees it.
  always_comb begin
    for (int n = 0; n < 16; n++) begin
      a_re_f[n] = a_re[n];
      a_im_f[n] = a_im[n];
      b_re_f[n] = b_re[n];
      b_im_f[n] = b_im[n];
    end
    if (load_ok && !LoadSel) begin
      a_re_f[LoadAddr] = LoadReal;
      a_im_f[LoadAddr] = LoadImag;
    end
    if (load_ok && LoadSel) begin
      b_re_f[LoadAddr] = LoadReal;
      b_im_f[LoadAddr] = LoadImag;
    end
    fr_nx = '0;
    fi_nx = '0;
    cr_nx = '0;
    ci_nx = '0;
    for (int k = 0; k < 4; k++) begin
      fr_nx[k*Width +: Width] = a_re_f[{nx_idx[3:2], 2'(k)}];
      fi_nx[k*Width +: Width] = a_im_f[{nx_idx[3:2], 2'(k)}];
      cr_nx[k*Width +: Width] = b_re_f[{2'(k), nx_idx[1:0]}];
      ci_nx[k*Width +: Width] = b_im_f[{2'(k), nx_idx[1:0]}];
    end
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE, DONE: if (Start) state_nx = ISSUE;
      ISSUE:      state_nx = WAIT;
      WAIT: begin
        if (MulListo) state_nx = CAPTURE;
`ifdef SECUENCIADOR_TIMEOUT_EN
        else if (wd == 8'hFF) state_nx = RELEASE;
`endif
      end
      CAPTURE:    state_nx = RELEASE;
      RELEASE: begin
        if (!MulListo) state_nx = (idx == 4'd15) ? DONE : ISSUE;
      end
      default:    state_nx = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (MasterReset) begin
      state    <= IDLE;
      idx      <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      err_mask <= '0;
      FilaReal <= '0;
      FilaImag <= '0;
      ColumReal <= '0;
      ColumImag <= '0;
      for (int n = 0; n < 16; n++) begin
        a_re[n] <= '0;
        a_im[n] <= '0;
        b_re[n] <= '0;
        b_im[n] <= '0;
        c_re[n] <= '0;
        c_im[n] <= '0;
      end
`ifdef SECUENCIADOR_TIMEOUT_EN
      wd <= '0;
`endif
    end else begin
      state <= state_nx;
      if (load_ok && !LoadSel) begin
        a_re[LoadAddr] <= LoadReal;
        a_im[LoadAddr] <= LoadImag;
      end
      if (load_ok && LoadSel) begin
        b_re[LoadAddr] <= LoadReal;
        b_im[LoadAddr] <= LoadImag;
      end
      if (start_ok) begin
        busy     <= 1'b1;
        done     <= 1'b0;
        err_mask <= '0;
      end
      if (state_nx == ISSUE) begin
        idx       <= nx_idx;
        FilaReal  <= fr_nx;
        FilaImag  <= fi_nx;
        ColumReal <= cr_nx;
        ColumImag <= ci_nx;
      end
      if (state == CAPTURE) begin
        c_re[idx]     <= MulOutReal;
        c_im[idx]     <= MulOutImag;
        err_mask[idx] <= MulError;
      end
      if (state == RELEASE && !MulListo && idx == 4'd15) begin
        busy <= 1'b0;
        done <= 1'b1;
      end
`ifdef SECUENCIADOR_TIMEOUT_EN
      if (state == ISSUE) wd <= '0;
      else if (state == WAIT && wd != 8'hFF) wd <= wd + 8'd1;
      if (state == WAIT && !MulListo && wd == 8'hFF) begin
        c_re[idx]     <= '0;
        c_im[idx]     <= '0;
        err_mask[idx] <= 1'b1;
      end
`endif
    end
  end

  assign Busy      = busy;
  assign Done      = done;
  assign MulEnable = busy;
  assign MulStart  = (state == ISSUE);
  assign ErrorMask = err_mask;
  assign ErrorAny  = |err_mask;
  assign RdReal    = c_re[RdAddr];
  assign RdImag    = c_im[RdAddr];
endmodule

// File: tb/tb_secuenciador_matriz_4x4.sv
// Randomized bench for secuenciador_matriz_4x4 with a matrix-product model
// and a behavioural multiplier attached to the handshake.
module tb_secuenciador_matriz_4x4;
  localparam int W = 8;

  logic CLK = 1'b0;
  always #5 CLK = ~CLK;

  logic MasterReset, LoadEn, LoadSel, Start;
  logic [3:0] LoadAddr, RdAddr;
  logic [W-1:0] LoadReal, LoadImag;
  logic Busy, Done, MulEnable, MulStart;
  logic [4*W-1:0] FilaReal, FilaImag, ColumReal, ColumImag;
  logic MulListo, MulError;
  logic [W-1:0] MulOutReal, MulOutImag, RdReal, RdImag;
  logic [15:0] ErrorMask;
  logic ErrorAny;

  secuenciador_matriz_4x4 #(.Width(W)) dut (
    .CLK(CLK), .MasterReset(MasterReset), .LoadEn(LoadEn),
    .LoadSel(LoadSel), .LoadAddr(LoadAddr), .LoadReal(LoadReal),
    .LoadImag(LoadImag), .Start(Start), .Busy(Busy), .Done(Done),
    .MulEnable(MulEnable), .MulStart(MulStart), .FilaReal(FilaReal),
    .FilaImag(FilaImag), .ColumReal(ColumReal), .ColumImag(ColumImag),
    .MulListo(MulListo), .MulOutReal(MulOutReal),
    .MulOutImag(MulOutImag), .MulError(MulError), .RdAddr(RdAddr),
    .RdReal(RdReal), .RdImag(RdImag), .ErrorMask(ErrorMask),
    .ErrorAny(ErrorAny)
  );

  int vectors = 0;
  int miscompares = 0;
  logic [W-1:0] ma_re [16];
  logic [W-1:0] ma_im [16];
  logic [W-1:0] mb_re [16];
  logic [W-1:0] mb_im [16];
  int lat_cfg = 2;
  int hold_cfg = 1;
  int err_elem = -1;
  int mute_elem = -1;
  int pulses = 0;
  int done_rises = 0;

  task automatic chk(input string name, input logic [63:0] got,
                     input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Full complex dot product of row i of A and column j of B, wrapped to W.
  function automatic logic [2*W-1:0] prod(input int n);
    int i, j, sr, si, ar, ai, br, bi;
    i = n / 4;
    j = n % 4;
    sr = 0;
    si = 0;
    for (int k = 0; k < 4; k++) begin
      ar = int'(signed'(ma_re[i*4+k]));
      ai = int'(signed'(ma_im[i*4+k]));
      br = int'(signed'(mb_re[k*4+j]));
      bi = int'(signed'(mb_im[k*4+j]));
      sr += ar*br - ai*bi;
      si += ar*bi + ai*br;
    end
    return {W'(sr), W'(si)};
  endfunction

  // Multiplier: computes from the presented buses, answers after a latency.
  initial begin
    int lat_c, hold_c, mcount, cur, sr, si, ar, ai, br, bi;
    lat_c = 0; hold_c = 0; mcount = 0; cur = 0;
    MulListo = 0; MulOutReal = 0; MulOutImag = 0; MulError = 0;
    forever begin
      @(posedge CLK); #1;
      if (!Busy) begin
        lat_c = 0; hold_c = 0; mcount = 0; MulListo = 0;
      end else if (MulStart) begin
        cur = mcount;
        mcount++;
        sr = 0; si = 0;
        for (int k = 0; k < 4; k++) begin
          ar = int'(signed'(FilaReal[k*W +: W]));
          ai = int'(signed'(FilaImag[k*W +: W]));
          br = int'(signed'(ColumReal[k*W +: W]));
          bi = int'(signed'(ColumImag[k*W +: W]));
          sr += ar*br - ai*bi;
          si += ar*bi + ai*br;
        end
        lat_c = (lat_cfg > 0) ? lat_cfg : int'($urandom_range(1, 5));
        MulListo = 0;
      end else if (lat_c > 0) begin
        lat_c--;
        if (lat_c == 0 && cur != mute_elem) begin
          MulListo = 1;
          MulOutReal = W'(sr);
          MulOutImag = W'(si);
          MulError = (cur == err_elem);
          hold_c = hold_cfg;
        end
      end else if (hold_c > 0) begin
        hold_c--;
        if (hold_c == 0) MulListo = 0;
      end
    end
  end

  // Per-cycle checks of handshake outputs and presented operands.
  initial begin
    logic prev_start, prev_done;
    int n;
    prev_start = 0;
    prev_done = 0;
    forever begin
      @(negedge CLK);
      if (!MasterReset) begin
        chk("mul_enable", MulEnable, Busy);
        chk("error_any", ErrorAny, |ErrorMask);
        chk("busy_done_excl", Busy & Done, 0);
        if (MulStart) begin
          n = pulses;
          chk("start_width", prev_start, 0);
          for (int k = 0; k < 4; k++) begin
            chk("fila_re", FilaReal[k*W +: W], ma_re[(n/4)*4+k]);
            chk("fila_im", FilaImag[k*W +: W], ma_im[(n/4)*4+k]);
            chk("colum_re", ColumReal[k*W +: W], mb_re[k*4+n%4]);
            chk("colum_im", ColumImag[k*W +: W], mb_im[k*4+n%4]);
          end
          pulses++;
        end
        if (Done && !prev_done) done_rises++;
      end
      prev_start = MulStart;
      prev_done = Done;
    end
  end

  task automatic tick();
    @(posedge CLK); #1;
  endtask

  task automatic load(input bit sel, input int addr,
                      input logic [W-1:0] re, input logic [W-1:0] im);
    LoadEn = 1; LoadSel = sel; LoadAddr = 4'(addr);
    LoadReal = re; LoadImag = im;
    tick();
    LoadEn = 0;
    if (!sel) begin ma_re[addr] = re; ma_im[addr] = im; end
    else begin mb_re[addr] = re; mb_im[addr] = im; end
  endtask

  task automatic start_pulse();
    pulses = 0;
    done_rises = 0;
    Start = 1;
    tick();
    Start = 0;
  endtask

  task automatic wait_done(input string tag);
    int n;
    n = 0;
    while (!Done && n < 20000) begin
      tick();
      n++;
    end
    chk({tag, "_done"}, Done, 1);
    chk({tag, "_busy"}, Busy, 0);
  endtask

  task automatic check_results(input string tag);
    logic [15:0] em;
    em = '0;
    if (err_elem >= 0) em[err_elem] = 1'b1;
    if (mute_elem >= 0) em[mute_elem] = 1'b1;
    for (int n = 0; n < 16; n++) begin
      RdAddr = 4'(n);
      #1;
      if (n == mute_elem) chk({tag, "_c_timeout"}, {RdReal, RdImag}, 0);
      else chk({tag, "_c"}, {RdReal, RdImag}, prod(n));
    end
    chk({tag, "_mask"}, ErrorMask, em);
    chk({tag, "_pulses"}, pulses, 16);
    chk({tag, "_done_once"}, done_rises, 1);
  endtask

  task automatic load_random();
    for (int n = 0; n < 16; n++) begin
      load(0, n, W'($urandom), W'($urandom));
      load(1, n, W'($urandom), W'($urandom));
    end
  endtask

  task automatic zero_model();
    for (int n = 0; n < 16; n++) begin
      ma_re[n] = 0; ma_im[n] = 0; mb_re[n] = 0; mb_im[n] = 0;
    end
  endtask

  initial begin
    int n;
    logic [W-1:0] v;
    MasterReset = 1; LoadEn = 0; LoadSel = 0; LoadAddr = 0;
    LoadReal = 0; LoadImag = 0; Start = 0; RdAddr = 0;
    zero_model();
    tick(); tick();
    MasterReset = 0;
    tick();
    chk("rst_busy", Busy, 0);
    chk("rst_done", Done, 0);
    chk("rst_mulstart", MulStart, 0);
    chk("rst_mask", ErrorMask, 0);
    chk("rst_fila", {FilaReal, FilaImag}, 0);
    chk("rst_colum", {ColumReal, ColumImag}, 0);
    for (int k = 0; k < 16; k++) begin
      RdAddr = 4'(k); #1;
      chk("rst_c", {RdReal, RdImag}, 0);
    end

    // Identity A, B[n] = (n, -n).
    for (int k = 0; k < 16; k++) begin
      load(0, k, (k % 5 == 0) ? 8'd1 : 8'd0, 8'd0);
      load(1, k, W'(k), W'(-k));
    end
    lat_cfg = 0; hold_cfg = 1;
    start_pulse();
    wait_done("ident");
    check_results("ident");
    for (int k = 0; k < 16; k++) begin
      RdAddr = 4'(k); #1;
      v = W'(k);
      chk("ident_lit", {RdReal, RdImag}, {v, W'(-k)});
    end
    chk("ident_errany", ErrorAny, 0);

    // A all (1,1), B all (1,0); A[0] written in the Start cycle.
    for (int k = 1; k < 16; k++) load(0, k, 8'd1, 8'd1);
    for (int k = 0; k < 16; k++) load(1, k, 8'd1, 8'd0);
    pulses = 0; done_rises = 0;
    LoadEn = 1; LoadSel = 0; LoadAddr = 0; LoadReal = 1; LoadImag = 1;
    Start = 1;
    ma_re[0] = 1; ma_im[0] = 1;
    tick();
    LoadEn = 0; Start = 0;
    wait_done("ones");
    check_results("ones");
    for (int k = 0; k < 16; k++) begin
      RdAddr = 4'(k); #1;
      chk("ones_lit", {RdReal, RdImag}, 16'h0404);
    end

    // Random operands, error reported only for element 6.
    load_random();
    err_elem = 6; lat_cfg = 3;
    start_pulse();
    wait_done("err6");
    check_results("err6");
    chk("err6_lit", ErrorMask, 16'h0040);
    chk("err6_any", ErrorAny, 1);
    err_elem = -1;

    // Listo held 5 cycles; Start and writes during Busy are ignored.
    load_random();
    lat_cfg = 2; hold_cfg = 5;
    start_pulse();
    repeat (30) tick();
    Start = 1;
    LoadEn = 1; LoadSel = 1; LoadAddr = 4'd15;
    LoadReal = ~mb_re[15]; LoadImag = ~mb_im[15];
    tick();
    Start = 0; LoadEn = 0;
    wait_done("hold5");
    check_results("hold5");
    hold_cfg = 1;

    // Reset while waiting on element 9.
    load_random();
    lat_cfg = 8;
    start_pulse();
    n = 0;
    while (pulses < 10 && n < 2000) begin
      tick();
      n++;
    end
    chk("rst9_reached", pulses, 10);
    chk("rst9_waiting", {Busy, MulStart, MulListo}, 3'b100);
    MasterReset = 1;
    tick();
    MasterReset = 0;
    zero_model();
    chk("rst9_busy", Busy, 0);
    chk("rst9_done", Done, 0);
    chk("rst9_mask", ErrorMask, 0);
    for (int k = 0; k < 16; k++) begin
      RdAddr = 4'(k); #1;
      chk("rst9_c", {RdReal, RdImag}, 0);
    end
    tick();
    load_random();
    lat_cfg = 0;
    start_pulse();
    wait_done("after_rst");
    check_results("after_rst");

`ifdef SECUENCIADOR_TIMEOUT_EN
    load_random();
    mute_elem = 3; lat_cfg = 2;
    start_pulse();
    wait_done("timeout");
    check_results("timeout");
    chk("timeout_mask3", ErrorMask[3], 1);
    mute_elem = -1;
`endif

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end
endmodule
